// File: rtl/tdma_dispatcher.sv
// TDMA dispatcher: pops the granted request queue and forwards its head entry through one registered slot.
// Optional statistics counters are built when TDMA_DISPATCH_STATS_EN is defined.
module tdma_dispatcher #(
  parameter  int NUMBER_OF_QUEUES = 4,
  parameter  int DATA_WIDTH       = 64,
  parameter  int REGISTER_SIZE    = 32,
  localparam int SEL_W            = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             sched_valid,
  input  logic [SEL_W-1:0]                                 sched_selection,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]      queue_data,
  input  logic [NUMBER_OF_QUEUES-1:0]                      queue_empty,
  output logic [NUMBER_OF_QUEUES-1:0]                      queue_pop,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [DATA_WIDTH-1:0]                            out_data,
  output logic [SEL_W-1:0]                                 out_source,
  input  logic                                             stats_clear,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   served_count,
  output logic [REGISTER_SIZE-1:0]                         stale_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   sel_in_range;
  logic   sel_empty;
  logic   drain;
  logic   accept;
  logic   stale;

  // Grant qualification; reset gates the pop so nothing leaves a queue while held in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_in_range = int'(sched_selection) < NUMBER_OF_QUEUES;
    sel_empty    = 1'b1;
    if (sel_in_range) sel_empty = queue_empty[sched_selection];
    drain  = (state_q == ST_FULL) && out_ready;
    accept = reset && sched_valid && sel_in_range && !sel_empty &&
             ((state_q == ST_EMPTY) || drain);
    stale  = reset && sched_valid && (!sel_in_range || sel_empty);
  end

  always_comb begin
    queue_pop = '0;
    if (accept) queue_pop[sched_selection] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain)  state_d = accept ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q    <= ST_EMPTY;
      out_data   <= '0;
      out_source <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data   <= queue_data[sched_selection];
        out_source <= sched_selection;
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);

`ifdef TDMA_DISPATCH_STATS_EN
  localparam logic [REGISTER_SIZE-1:0] CNT_MAX = '1;

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_q;
  logic [REGISTER_SIZE-1:0]                       stale_q;

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      served_q <= '0;
      stale_q  <= '0;
    end else if (stats_clear) begin
      served_q <= '0;
      stale_q  <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        if (queue_pop[i] && (served_q[i] != CNT_MAX)) served_q[i] <= served_q[i] + 1'b1;
      end
      if (stale && (stale_q != CNT_MAX)) stale_q <= stale_q + 1'b1;
    end
  end

  assign served_count = served_q;
  assign stale_count  = stale_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clear ^ stale;
  assign served_count = '0;
  assign stale_count  = '0;
`endif

endmodule

// File: tb/tb_tdma_dispatcher.sv
// Self-checking bench for tdma_dispatcher: directed vectors, a slot/counter model checked every cycle,
// and a narrow-counter instance for saturation. Honors TDMA_DISPATCH_STATS_EN like the RTL.
module tb_tdma_dispatcher;
  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int RS = 32;
  localparam int RS_SMALL = 4;
`ifdef TDMA_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   sched_valid = 1'b0;
  logic [1:0]             sched_selection = '0;
  logic [NQ-1:0][DW-1:0]  queue_data = '0;
  logic [NQ-1:0]          queue_empty = '1;
  logic                   out_ready = 1'b0;
  logic                   stats_clear = 1'b0;

  logic [NQ-1:0]          queue_pop;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [1:0]             out_source;
  logic [NQ-1:0][RS-1:0]  served_count;
  logic [RS-1:0]          stale_count;

  logic [NQ-1:0]                s_queue_pop;
  logic                         s_out_valid;
  logic [DW-1:0]                s_out_data;
  logic [1:0]                   s_out_source;
  logic [NQ-1:0][RS_SMALL-1:0]  s_served_count;
  logic [RS_SMALL-1:0]          s_stale_count;

  always #5 clock = ~clock;

  tdma_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .REGISTER_SIZE(RS)) dut (
    .clock(clock), .reset(reset), .sched_valid(sched_valid), .sched_selection(sched_selection),
    .queue_data(queue_data), .queue_empty(queue_empty), .queue_pop(queue_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_source(out_source),
    .stats_clear(stats_clear), .served_count(served_count), .stale_count(stale_count)
  );

  tdma_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .REGISTER_SIZE(RS_SMALL)) dut_small (
    .clock(clock), .reset(reset), .sched_valid(sched_valid), .sched_selection(sched_selection),
    .queue_data(queue_data), .queue_empty(queue_empty), .queue_pop(s_queue_pop),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_source(s_out_source),
    .stats_clear(stats_clear), .served_count(s_served_count), .stale_count(s_stale_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected counter value: plain count clipped to the counter width, zero when stats are not built.
  function automatic logic [63:0] exp_cnt(input int cnt, input int width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    if (!STATS) return 64'd0;
    if (64'(cnt) > max_v) return max_v;
    return 64'(cnt);
  endfunction

  // Reference model: the slot is either empty or holds one (data, source) pair.
  bit          m_full = 1'b0;
  logic [63:0] m_data = '0;
  logic [1:0]  m_src = '0;
  int          cnt_served[NQ];
  int          cnt_stale = 0;

  initial begin
    logic          acc;
    logic          stl;
    logic [NQ-1:0] exp_pop;
    for (int i = 0; i < NQ; i++) cnt_served[i] = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        m_full = 1'b0; m_data = '0; m_src = '0; cnt_stale = 0;
        for (int i = 0; i < NQ; i++) cnt_served[i] = 0;
      end
      acc = 1'b0;
      stl = 1'b0;
      exp_pop = '0;
      if (reset && sched_valid) begin
        if (queue_empty[sched_selection]) stl = 1'b1;
        else if (!m_full || out_ready) acc = 1'b1;
      end
      if (acc) exp_pop[sched_selection] = 1'b1;
      check("pop", 64'(queue_pop), 64'(exp_pop));
      check("pop_small", 64'(s_queue_pop), 64'(exp_pop));
      check("valid", 64'(out_valid), 64'(m_full));
      check("valid_small", 64'(s_out_valid), 64'(m_full));
      if (m_full || !reset) begin
        check("data", out_data, m_data);
        check("source", 64'(out_source), 64'(m_src));
      end
      for (int i = 0; i < NQ; i++) begin
        check($sformatf("served%0d", i), 64'(served_count[i]), exp_cnt(cnt_served[i], RS));
        check($sformatf("served_small%0d", i), 64'(s_served_count[i]), exp_cnt(cnt_served[i], RS_SMALL));
      end
      check("stale", 64'(stale_count), exp_cnt(cnt_stale, RS));
      check("stale_small", 64'(s_stale_count), exp_cnt(cnt_stale, RS_SMALL));
      @(posedge clock);
      if (reset) begin
        if (stats_clear) begin
          cnt_stale = 0;
          for (int i = 0; i < NQ; i++) cnt_served[i] = 0;
        end else begin
          if (acc) cnt_served[sched_selection]++;
          if (stl) cnt_stale++;
        end
        if (acc) begin
          m_full = 1'b1;
          m_data = queue_data[sched_selection];
          m_src  = sched_selection;
        end else if (m_full && out_ready) begin
          m_full = 1'b0;
        end
      end
    end
  end

  task automatic step(input logic rst, input logic v, input logic [1:0] sel, input logic [3:0] emp,
                      input logic rdy, input logic clr, input logic [63:0] d);
    @(negedge clock);
    cyc++;
    reset = rst;
    sched_valid = v;
    sched_selection = sel;
    queue_empty = emp;
    out_ready = rdy;
    stats_clear = clr;
    for (int i = 0; i < NQ; i++) queue_data[i] = {8'(i + 1), 24'h0, 32'(cyc)};
    queue_data[sel] = d;
    #1;
  endtask

  initial begin
    // Reset held with a live grant: nothing pops, slot empty, counters zero.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 4'b0000, 0, 0, 64'h0);
      check("rst_pop", 64'(queue_pop), 64'h0);
      check("rst_valid", 64'(out_valid), 64'h0);
    end
    check("rst_stale", 64'(stale_count), 64'h0);
    check("rst_served1", 64'(served_count[1]), 64'h0);

    // Release: the grant is taken at the very next rising edge.
    step(1, 1, 1, 4'b0000, 0, 0, 64'hBEEF);
    check("rel_pop", 64'(queue_pop), 64'h2);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("rel_valid", 64'(out_valid), 64'h1);
    check("rel_data", out_data, 64'hBEEF);
    check("rel_src", 64'(out_source), 64'h1);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("rel_drained", 64'(out_valid), 64'h0);
    check("rel_served1", 64'(served_count[1]), STATS ? 64'h1 : 64'h0);

    // Single grant from queue 2.
    step(1, 1, 2, 4'b0000, 1, 0, 64'hA5);
    check("sg_pop", 64'(queue_pop), 64'h4);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("sg_valid", 64'(out_valid), 64'h1);
    check("sg_data", out_data, 64'hA5);
    check("sg_src", 64'(out_source), 64'h2);
    check("sg_served2", 64'(served_count[2]), STATS ? 64'h1 : 64'h0);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("sg_drained", 64'(out_valid), 64'h0);

    // Backpressure: slot holds queue 1 while queue 3 is granted.
    step(1, 1, 1, 4'b0000, 0, 0, 64'h11);
    check("bp_pop1", 64'(queue_pop), 64'h2);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 3, 4'b0000, 0, 0, 64'h30 + 64'(k));
      check("bp_nopop", 64'(queue_pop), 64'h0);
      check("bp_valid", 64'(out_valid), 64'h1);
      check("bp_hold", out_data, 64'h11);
      check("bp_stale", 64'(stale_count), 64'h0);
    end
    step(1, 1, 3, 4'b0000, 1, 0, 64'h33);
    check("bp_pass_pop", 64'(queue_pop), 64'h8);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("bp_next_valid", 64'(out_valid), 64'h1);
    check("bp_next_data", out_data, 64'h33);
    check("bp_next_src", 64'(out_source), 64'h3);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("bp_drained", 64'(out_valid), 64'h0);

    // Stale grant to an empty queue.
    step(1, 1, 0, 4'b0001, 1, 0, 64'h0);
    check("st_pop", 64'(queue_pop), 64'h0);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("st_valid", 64'(out_valid), 64'h0);
    check("st_count", 64'(stale_count), STATS ? 64'h1 : 64'h0);

    // Streaming eight back-to-back entries from queue 1 after a clear.
    step(1, 0, 0, 4'b0000, 1, 1, 64'h0);
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 1, 4'b0000, 1, 0, 64'h100 + 64'(k));
      check("str_pop", 64'(queue_pop), 64'h2);
      if (k > 0) begin
        check("str_valid", 64'(out_valid), 64'h1);
        check("str_data", out_data, 64'h100 + 64'(k - 1));
      end
    end
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("str_last_valid", 64'(out_valid), 64'h1);
    check("str_last_data", out_data, 64'h107);
    check("str_served1", 64'(served_count[1]), STATS ? 64'h8 : 64'h0);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("str_drained", 64'(out_valid), 64'h0);

    // Saturation on the 4-bit instance; clear beats a simultaneous pop.
    step(1, 0, 0, 4'b0000, 1, 1, 64'h0);
    for (int k = 0; k < 20; k++) step(1, 1, 0, 4'b0000, 1, 0, 64'(k));
    for (int k = 0; k < 20; k++) step(1, 1, 2, 4'b0100, 1, 0, 64'h0);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("sat_served0", 64'(served_count[0]), STATS ? 64'd20 : 64'h0);
    check("sat_served0_small", 64'(s_served_count[0]), STATS ? 64'hF : 64'h0);
    check("sat_stale", 64'(stale_count), STATS ? 64'd20 : 64'h0);
    check("sat_stale_small", 64'(s_stale_count), STATS ? 64'hF : 64'h0);
    step(1, 1, 0, 4'b0000, 1, 1, 64'h77);
    check("clr_pop", 64'(queue_pop), 64'h1);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("clr_served0", 64'(served_count[0]), 64'h0);
    check("clr_served0_small", 64'(s_served_count[0]), 64'h0);
    check("clr_stale", 64'(stale_count), 64'h0);
    check("clr_data", out_data, 64'h77);

    // Reset mid-transfer drops the held entry without waiting for an edge.
    step(1, 1, 2, 4'b0000, 0, 0, 64'hCC);
    step(1, 0, 0, 4'b0000, 0, 0, 64'h0);
    check("mid_valid", 64'(out_valid), 64'h1);
    check("mid_data", out_data, 64'hCC);
    step(0, 1, 2, 4'b0000, 0, 0, 64'h0);
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_data", out_data, 64'h0);
    check("mid_rst_pop", 64'(queue_pop), 64'h0);
    step(1, 0, 0, 4'b0000, 1, 0, 64'h0);
    check("mid_after", 64'(out_valid), 64'h0);

    @(negedge clock);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
